// File: rtl/cpu_irq_pkg.sv
// Shared state encoding and cause codes for the interrupt/exception sequencer.
package cpu_irq_pkg;

   typedef enum logic [1:0] {
      ST_USER   = 2'd0,
      ST_KERNEL = 2'd1,
      ST_GUARD  = 2'd2
   } irq_state_t;

   localparam logic [3:0] CAUSE_EXC  = 4'b1000;
   localparam logic [3:0] CAUSE_NONE = 4'b0000;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending requests.
module irq_prio_enc #(
   parameter int N_IRQ = 4
) (
   input  logic [N_IRQ-1:0] i_req,
   output logic             o_valid,
   output logic [2:0]       o_idx
);

   always_comb begin
      o_valid = |i_req;
      o_idx   = 3'd0;
      // Walk downwards so the lowest set index is the last one written.
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (i_req[i]) o_idx = 3'(i);
      end
   end

endmodule

// File: rtl/cpu_irq_ctrl.sv
// Interrupt/exception sequencer: latches request edges, arbitrates them and replaces
// committing user instructions; GUARD state guarantees one user instruction between interrupts.
module cpu_irq_ctrl
   import cpu_irq_pkg::*;
#(
   parameter int N_IRQ = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [N_IRQ-1:0] i_irq_src,
   input  logic [N_IRQ-1:0] i_irq_en,
   input  logic             i_pc_high,
   input  logic             i_commit,
   input  logic             i_undef,
   output logic             o_interrupt,
   output logic             o_exception,
   output logic [3:0]       o_cause,
   output logic [N_IRQ-1:0] o_pending,
   output logic             o_in_handler,
   output logic             o_fault
);

   irq_state_t       r_state;
   logic [N_IRQ-1:0] r_irq_d;
   logic [N_IRQ-1:0] r_pending;
   logic [3:0]       r_cause;
   logic             r_fault;

   logic             w_user_commit;
   logic             w_exc;
   logic             w_int;
   logic             w_win_vld;
   logic [2:0]       w_win_idx;
   logic [N_IRQ-1:0] w_rise;
   logic [N_IRQ-1:0] w_clr;

   irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
      .i_req   (r_pending & i_irq_en),
      .o_valid (w_win_vld),
      .o_idx   (w_win_idx)
   );

   assign w_user_commit = i_commit & ~i_pc_high;
   assign w_exc  = (r_state == ST_USER || r_state == ST_GUARD) & w_user_commit & i_undef;
   assign w_int  = (r_state == ST_USER) & w_user_commit & ~i_undef & w_win_vld;
   assign w_rise = i_irq_src & ~r_irq_d & i_irq_en;

   always_comb begin
      w_clr = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         w_clr[i] = w_int & (w_win_idx == 3'(i));
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= ST_USER;
         r_irq_d   <= '1;
         r_pending <= '0;
         r_cause   <= CAUSE_NONE;
         r_fault   <= 1'b0;
      end else begin
         r_irq_d   <= i_irq_src;
         // A fresh edge on the source being taken survives the clear.
         r_pending <= (r_pending & ~w_clr) | w_rise;
         if (i_commit & i_pc_high & i_undef) r_fault <= 1'b1;
         case (r_state)
            ST_USER: begin
               if (w_exc) begin
                  r_state <= ST_KERNEL;
                  r_cause <= CAUSE_EXC;
               end else if (w_int) begin
                  r_state <= ST_KERNEL;
                  r_cause <= {1'b0, w_win_idx};
               end
            end
            ST_KERNEL: begin
               if (!i_pc_high) r_state <= ST_GUARD;
            end
            ST_GUARD: begin
               if (w_exc) begin
                  r_state <= ST_KERNEL;
                  r_cause <= CAUSE_EXC;
               end else if (w_user_commit) begin
                  r_state <= ST_USER;
               end
            end
            default: r_state <= ST_USER;
         endcase
      end
   end

   assign o_interrupt  = w_int;
   assign o_exception  = w_exc;
   assign o_cause      = r_cause;
   assign o_pending    = r_pending;
   assign o_in_handler = (r_state == ST_KERNEL);
   assign o_fault      = r_fault;

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Scoreboard bench for cpu_irq_ctrl: directed per-cycle vectors queue their expected outputs,
// a negedge monitor pops and compares them.
module tb_cpu_irq_ctrl;

   typedef struct packed {
      logic       irq;
      logic       exc;
      logic [3:0] cause;
      logic [3:0] pend;
      logic       inh;
      logic       flt;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] irq_src = 4'b0001;
   logic [3:0] irq_en = 4'hF;
   logic       pc_high = 1'b0;
   logic       commit = 1'b0;
   logic       undef = 1'b0;
   logic       interrupt;
   logic       exception;
   logic [3:0] cause;
   logic [3:0] pending;
   logic       in_handler;
   logic       fault;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_pass = 0;

   always #5 clk = ~clk;

   cpu_irq_ctrl #(.N_IRQ(4)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_irq_src    (irq_src),
      .i_irq_en     (irq_en),
      .i_pc_high    (pc_high),
      .i_commit     (commit),
      .i_undef      (undef),
      .o_interrupt  (interrupt),
      .o_exception  (exception),
      .o_cause      (cause),
      .o_pending    (pending),
      .o_in_handler (in_handler),
      .o_fault      (fault)
   );

   task automatic check(input string nm, input string fld, input logic [3:0] got, input logic [3:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s.%s got=%b want=%b @%0t", nm, fld, got, want, $time);
   endtask

   // Monitor: every cycle the DUT presents a fresh output set, compare it with the queued one.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         check(nm, "interrupt",  {3'b0, interrupt},  {3'b0, e.irq});
         check(nm, "exception",  {3'b0, exception},  {3'b0, e.exc});
         check(nm, "cause",      cause,              e.cause);
         check(nm, "pending",    pending,            e.pend);
         check(nm, "in_handler", {3'b0, in_handler}, {3'b0, e.inh});
         check(nm, "fault",      {3'b0, fault},      {3'b0, e.flt});
      end
   end

   task automatic step(input logic rst, input logic [3:0] src, input logic pch, input logic com,
                       input logic und, input logic ei, input logic ee, input logic [3:0] ec,
                       input logic [3:0] ep, input logic eh, input logic ef, input string nm);
      exp_t e;
      reset   = rst;
      irq_src = src;
      pc_high = pch;
      commit  = com;
      undef   = und;
      e = '{irq: ei, exc: ee, cause: ec, pend: ep, inh: eh, flt: ef};
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #1;
      //   rst src     pch com und int exc cause    pend     inh flt
      repeat (2)  step(1, 4'b0001, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, "in_reset");
      repeat (10) step(0, 4'b0001, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, "held_high");
      step(0, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, "src0_fall");
      step(0, 4'b0001, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, "src0_rise");
      repeat (5)  step(0, 4'b0001, 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, "stall");
      step(0, 4'b0001, 0, 1, 0, 1, 0, 4'b0000, 4'b0001, 0, 0, "stall_release");
      step(0, 4'b0001, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, "take0");
      step(0, 4'b0001, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, "k0_ret");
      step(0, 4'b0001, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, "g0");

      step(0, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, "idle");
      step(0, 4'b0100, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, "src2_rise");
      step(0, 4'b0100, 0, 1, 0, 1, 0, 4'b0000, 4'b0100, 0, 0, "src2_t1");
      step(0, 4'b0100, 1, 1, 0, 0, 0, 4'b0010, 4'b0000, 1, 0, "src2_t2");
      step(0, 4'b0100, 0, 1, 0, 0, 0, 4'b0010, 4'b0000, 1, 0, "k2_ret");
      step(0, 4'b0100, 0, 1, 0, 0, 0, 4'b0010, 4'b0000, 0, 0, "g2");

      step(0, 4'b1110, 0, 0, 0, 0, 0, 4'b0010, 4'b0000, 0, 0, "src13_rise");
      step(0, 4'b1110, 0, 1, 0, 1, 0, 4'b0010, 4'b1010, 0, 0, "take1");
      step(0, 4'b1110, 1, 1, 0, 0, 0, 4'b0001, 4'b1000, 1, 0, "k1");
      step(0, 4'b1110, 0, 1, 0, 0, 0, 4'b0001, 4'b1000, 1, 0, "k1_ret");
      step(0, 4'b1110, 0, 1, 0, 0, 0, 4'b0001, 4'b1000, 0, 0, "guard_blocks");
      step(0, 4'b1110, 0, 1, 0, 1, 0, 4'b0001, 4'b1000, 0, 0, "take3");
      step(0, 4'b1110, 1, 1, 0, 0, 0, 4'b0011, 4'b0000, 1, 0, "k3");
      step(0, 4'b1110, 0, 1, 0, 0, 0, 4'b0011, 4'b0000, 1, 0, "k3_ret");
      step(0, 4'b1110, 0, 1, 0, 0, 0, 4'b0011, 4'b0000, 0, 0, "g3");

      step(0, 4'b1111, 0, 0, 0, 0, 0, 4'b0011, 4'b0000, 0, 0, "src0_rise2");
      step(0, 4'b1111, 0, 1, 1, 0, 1, 4'b0011, 4'b0001, 0, 0, "undef_user");
      step(0, 4'b1111, 1, 1, 1, 0, 0, 4'b1000, 4'b0001, 1, 0, "undef_kernel");
      step(0, 4'b1111, 1, 1, 0, 0, 0, 4'b1000, 4'b0001, 1, 1, "fault_set");
      step(0, 4'b1111, 0, 1, 0, 0, 0, 4'b1000, 4'b0001, 1, 1, "ke_ret");
      step(0, 4'b1111, 0, 1, 1, 0, 1, 4'b1000, 4'b0001, 0, 1, "undef_guard");
      step(0, 4'b1111, 1, 1, 0, 0, 0, 4'b1000, 4'b0001, 1, 1, "kg");
      step(0, 4'b1111, 0, 1, 0, 0, 0, 4'b1000, 4'b0001, 1, 1, "kg_ret");
      step(0, 4'b1111, 0, 1, 0, 0, 0, 4'b1000, 4'b0001, 0, 1, "g_pend");

      step(0, 4'b1110, 0, 0, 0, 0, 0, 4'b1000, 4'b0001, 0, 1, "src0_fall2");
      step(0, 4'b1111, 0, 1, 0, 1, 0, 4'b1000, 4'b0001, 0, 1, "take_and_rise");
      step(0, 4'b1111, 1, 1, 0, 0, 0, 4'b0000, 4'b0001, 1, 1, "set_wins");
      step(0, 4'b1011, 1, 1, 0, 0, 0, 4'b0000, 4'b0001, 1, 1, "src2_fall");
      step(0, 4'b1111, 1, 1, 0, 0, 0, 4'b0000, 4'b0001, 1, 1, "src2_rise_k");
      step(1, 4'b1111, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, "mid_reset");
      step(0, 4'b1111, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, "post_reset");

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cpu_irq_ctrl.md
# cpu_irq_ctrl

Interrupt/exception sequencer for the single-cycle MIPS core. It latches edge-triggered requests from the peripherals and arbitrates them by priority. Each cycle it decides whether the committing user-mode instruction is replaced by an interrupt or an exception, and drives the `Interrupt`/`Exception` inputs of the CPU control decoder. It tracks kernel-mode residency so that handlers are never re-entered and a user instruction is always guaranteed forward progress.

## Interface
Parameters:
- N_IRQ, 4, number of interrupt sources, 1..7

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- irq_src  in  N_IRQ  level request lines from peripherals, same clock domain
- irq_en  in  N_IRQ  per-source enable
- pc_high  in  1  PC[31]; 1 = kernel mode
- commit  in  1  current instruction retires this cycle (0 during stall)
- undef  in  1  decoder flags an unimplemented opcode this cycle
- interrupt  out  1  to decoder `Interrupt`
- exception  out  1  to decoder `Exception`
- cause  out  4  bit3 = exception, [2:0] = source index of last taken event
- pending  out  N_IRQ  latched pending flags
- in_handler  out  1  state == KERNEL
- fault  out  1  sticky: undef committed in kernel mode

## Operation
- Edge latch:
  - `irq_d` holds last-cycle `irq_src`.
  - `pending[i]` sets on `irq_src[i] & ~irq_d[i] & irq_en[i]`.
  - `pending[i]` clears when source i is taken.
  - Set and clear on the same bit in the same cycle: set wins.
  - Disabling `irq_en` does not clear an existing pending flag, but masks it from arbitration.
- Arbitration: lowest index among `pending & irq_en` wins.
- States:
  - USER (normal execution)
    - Exception: `exception = commit & ~pc_high & undef`.
    - Interrupt: `interrupt = commit & ~pc_high & ~undef & |(pending & irq_en)`.
    - On either: go to KERNEL and latch `cause`. An interrupt also clears the winner's pending bit.
    - An exception leaves pending flags untouched.
  - KERNEL
    - `interrupt` and `exception` are held at 0.
    - Go to GUARD when `pc_high == 0` is sampled (handler has executed `jr $k0`).
  - GUARD
    - `interrupt` is held at 0.
    - Exceptions are taken exactly as in USER.
    - Go to USER on the first `commit` with `pc_high == 0`.
- Kernel undef: `commit & pc_high & undef` in any state sets `fault`. There is no vectoring; `fault` clears only on reset.
- Both outputs are combinational from registered state plus `commit`, `undef` and `pc_high`. There is no path from `irq_src` to `interrupt`.

## Timing
- Reset values:
  - state = USER
  - `pending` = 0
  - `irq_d` = all ones
  - `cause` = 0
  - `fault` = 0
  - `interrupt` = `exception` = 0
  - `in_handler` = 0
- Because `irq_d` resets to all ones, a source held high across reset is not counted until it falls and rises again.
- Edge on `irq_src` sampled at cycle t: `pending` is visible at t+1. `interrupt` is asserted at t+1 at the earliest (if `commit` is high).
- `cause` and `in_handler` update at the edge ending the taking cycle.
- Stall (`commit` = 0): nothing is taken and `pending` is retained.
- Minimum spacing between two interrupts is one committed user instruction (GUARD state).
- Reset asserted mid-handler: immediate return to reset values; all pending requests are lost.

## Structure
- Package `cpu_irq_pkg`:
  - state encoding: USER = 2'd0, KERNEL = 2'd1, GUARD = 2'd2
  - `CAUSE_EXC` = 4'b1000
  - `CAUSE_NONE` = 4'b0000
- Sub-module `irq_prio_enc`: N_IRQ-wide lowest-index priority encoder. Outputs `valid` and 3-bit `idx`.

## Test plan
- Reset with `irq_src[0]` = 1 held: `pending` = 0 and `interrupt` = 0 for 10 cycles. Drop and raise the line: `pending[0]` = 1 one cycle after the rise.
- `irq_src[2]` rises at t, `irq_en` = 4'hF, `commit` = 1, `pc_high` = 0:
  - t+1: `pending` = 4'b0100, `interrupt` = 1.
  - t+2: `cause` = 4'b0010, `in_handler` = 1, `pending` = 0.
- `pending` = 4'b1010 while in USER:
  - Source 1 is taken first.
  - After `pc_high` falls, the next cycle's commit leaves GUARD with `interrupt` = 0.
  - Source 3 is taken on the following commit.
- `undef` = 1 with `pending` = 4'b0001, `commit` = 1, USER: `exception` = 1, `interrupt` = 0, `cause` = 4'b1000, `pending` stays 4'b0001.
- `commit` = 0 for 5 cycles with `pending[0]` set: `interrupt` = 0 throughout. It asserts in the first cycle `commit` = 1.
- Reset pulse while `in_handler` = 1 and `pending` = 4'b0100: next cycle state = USER, `pending` = 0, `cause` = 0, `fault` = 0.
